// File: rtl/exception_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exception_ctrl_pkg
// Shared definitions for the exception / eret flush controller:
//   - fsm_state_t          : controller state encoding
//   - DEFAULT_FLUSH_CYCLES : default number of cycles flush is held
//   - EXP_KIND_*           : meaning of the cp0_exp_en qualifier
// ---------------------------------------------------------------------------
package exception_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } fsm_state_t;

    localparam int unsigned DEFAULT_FLUSH_CYCLES = 32'd2;

    // Value of cp0_exp_en that identifies each kind of request.
    localparam logic EXP_KIND_ERET      = 1'b0;
    localparam logic EXP_KIND_EXCEPTION = 1'b1;

endpackage

// File: rtl/exception_flush_ctrl.sv
// ---------------------------------------------------------------------------
// exception_flush_ctrl
// Sequences a pipeline redirect after an exception or eret: accepts the
// request (committing CP0 in the same cycle), waits for outstanding bus
// traffic to drain, flushes the pipeline for FLUSH_CYCLES cycles, then
// holds a redirect request to fetch until it is accepted.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   exp_detect         - exception/eret seen this cycle
//   cp0_exp_en         - 1 = real exception, 0 = eret
//   exp_pc_address     - redirect target captured on acceptance
//   mem_outstanding    - data-bus transaction in flight
//   ifetch_busy        - instruction-fetch transaction in flight
//   redirect_ready     - fetch accepts the redirect
//   cp0_commit         - one-cycle CP0 commit pulse (acceptance cycle)
//   stall              - freeze PC and issue
//   flush              - kill all pipeline stages
//   redirect_valid     - redirect request to fetch
//   redirect_pc        - redirect target (holds last value when idle)
//   redirect_is_eret   - current redirect comes from an eret
//   busy               - controller not idle
//   exp_count          - saturating count of accepted real exceptions
// ---------------------------------------------------------------------------
module exception_flush_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int unsigned CNT_W        = 32'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_detect,
    input  logic             cp0_exp_en,
    input  logic [31:0]      exp_pc_address,
    input  logic             mem_outstanding,
    input  logic             ifetch_busy,
    input  logic             redirect_ready,
    output logic             cp0_commit,
    output logic             stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             redirect_is_eret,
    output logic             busy,
    output logic [CNT_W-1:0] exp_count
);

    localparam int unsigned      FCNT_W     = 32'd4;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    fsm_state_t        state_r;
    fsm_state_t        state_nxt_s;
    logic [31:0]       tgt_r;
    logic              eret_r;
    logic [FCNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0]  exp_count_r;
    logic [31:0]       redirect_pc_r;
    logic              accept_s;
    logic              fcnt_load_s;
    logic              fcnt_dec_s;
    logic              rpc_load_s;
    logic              bus_busy_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    assign bus_busy_s = mem_outstanding | ifetch_busy;

    // Next-state and control-strobe decode for the flush sequence.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        fcnt_load_s = 1'b0;
        fcnt_dec_s  = 1'b0;
        rpc_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // rst gating keeps cp0_commit/stall low while reset is held.
                if (exp_detect && !rst) begin
                    accept_s = 1'b1;
                    if (bus_busy_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        fcnt_load_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy_s) begin
                    state_nxt_s = ST_FLUSH;
                    fcnt_load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                // Counter holds the flush cycles remaining, including this one.
                if (flush_cnt_r <= 4'd1) begin
                    state_nxt_s = ST_REDIRECT;
                    rpc_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_FLUSH;
                    fcnt_dec_s  = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REDIRECT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture of target/kind on acceptance and the exception counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_r       <= 32'h0000_0000;
            eret_r      <= 1'b0;
            exp_count_r <= '0;
        end else if (accept_s) begin
            tgt_r  <= exp_pc_address;
            eret_r <= (cp0_exp_en == EXP_KIND_ERET);
            if (cp0_exp_en == EXP_KIND_EXCEPTION) begin
                exp_count_r <= sat_inc(exp_count_r);
            end
        end
    end

    // Flush duration down-counter and redirect target register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r   <= '0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            if (fcnt_load_s) begin
                flush_cnt_r <= FLUSH_LOAD;
            end else if (fcnt_dec_s) begin
                flush_cnt_r <= flush_cnt_r - 4'd1;
            end
            // Loaded only when entering REDIRECT so the value holds afterwards.
            if (rpc_load_s) begin
                redirect_pc_r <= tgt_r;
            end
        end
    end

    // Outputs decode directly from the state register, so they drop the
    // moment reset forces IDLE; only the acceptance strobes see live inputs.
    assign cp0_commit       = accept_s;
    assign stall            = (state_r != ST_IDLE) | accept_s;
    assign flush            = (state_r == ST_FLUSH);
    assign redirect_valid   = (state_r == ST_REDIRECT);
    assign redirect_is_eret = (state_r == ST_REDIRECT) & eret_r;
    assign redirect_pc      = redirect_pc_r;
    assign busy             = (state_r != ST_IDLE);
    assign exp_count        = exp_count_r;

endmodule
